// File: rtl/sb_requester.sv
`default_nettype none
// ============================================================================
// Module      : sb_requester
// Description : Scoreboard initiator. Buffers dispatcher commands in a FIFO and
//               runs them one at a time as read/write/flush strobes with a
//               timeout-guarded ack wait and a valid/ready response channel.
// Revision    : 1.0 - initial release
// ============================================================================
module sb_requester #(
  parameter int PROC_COUNT = 4,
  parameter int KEY_W      = 8,
  parameter int VAL_W      = 8,
  parameter int CMD_DEPTH  = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_cmd_valid,
  output logic                          o_cmd_ready,
  input  logic [1:0]                    i_cmd_op,
  input  logic [KEY_W-1:0]              i_cmd_key,
  input  logic [VAL_W-1:0]              i_cmd_val,
  output logic                          o_rsp_valid,
  input  logic                          i_rsp_ready,
  output logic [1:0]                    o_rsp_op,
  output logic                          o_rsp_hit,
  output logic [$clog2(PROC_COUNT)-1:0] o_rsp_id,
  output logic                          o_rsp_err,
  output logic [KEY_W-1:0]              o_sb_key,
  output logic [VAL_W-1:0]              o_sb_val,
  output logic                          o_sb_read,
  output logic                          o_sb_write,
  output logic                          o_sb_flush,
  input  logic                          i_sb_ack,
  input  logic                          i_sb_exists,
  input  logic [$clog2(PROC_COUNT)-1:0] i_sb_id,
  output logic                          o_busy,
  output logic                          o_spurious
);

  localparam int c_AW    = $clog2(CMD_DEPTH);
  localparam int c_CNT_W = $clog2(TIMEOUT + 1);
  localparam int c_ID_W  = $clog2(PROC_COUNT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t r_state, w_next;

  logic [1:0]       r_fifo_op  [CMD_DEPTH];
  logic [KEY_W-1:0] r_fifo_key [CMD_DEPTH];
  logic [VAL_W-1:0] r_fifo_val [CMD_DEPTH];
  logic [c_AW:0]    r_wr_ptr, r_rd_ptr;

  logic [c_CNT_W-1:0] r_cnt;
  logic [KEY_W-1:0]   r_key;
  logic [VAL_W-1:0]   r_val;
  logic [1:0]         r_rsp_op;
  logic               r_rsp_hit, r_rsp_err;
  logic [c_ID_W-1:0]  r_rsp_id;
  logic               r_sb_read, r_sb_write, r_sb_flush, r_spurious;

  logic             w_empty, w_full, w_push, w_pop, w_timeout;
  logic [1:0]       w_head_op;
  logic [KEY_W-1:0] w_head_key;
  logic [VAL_W-1:0] w_head_val;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                      (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign w_push     = i_cmd_valid && !w_full;
  assign w_pop      = (r_state == S_IDLE) && !w_empty;
  assign w_head_op  = r_fifo_op[r_rd_ptr[c_AW-1:0]];
  assign w_head_key = r_fifo_key[r_rd_ptr[c_AW-1:0]];
  assign w_head_val = r_fifo_val[r_rd_ptr[c_AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_op[r_wr_ptr[c_AW-1:0]]  <= i_cmd_op;
      r_fifo_key[r_wr_ptr[c_AW-1:0]] <= i_cmd_key;
      r_fifo_val[r_wr_ptr[c_AW-1:0]] <= i_cmd_val;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE:  if (!w_empty) w_next = (w_head_op == 2'd3) ? S_RESP : S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        if (i_sb_ack) begin
          w_next = S_RESP;
        end else if (r_cnt == c_CNT_W'(TIMEOUT - 1)) begin
          w_next    = S_RESP;
          w_timeout = 1'b1;
        end
      end
      S_RESP:  if (i_rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt      <= '0;
      r_key      <= '0;
      r_val      <= '0;
      r_rsp_op   <= '0;
      r_rsp_hit  <= 1'b0;
      r_rsp_id   <= '0;
      r_rsp_err  <= 1'b0;
      r_sb_read  <= 1'b0;
      r_sb_write <= 1'b0;
      r_sb_flush <= 1'b0;
      r_spurious <= 1'b0;
    end else begin
      // Strobes are launched by the pop, so they are high only in ISSUE.
      r_sb_read  <= w_pop && (w_head_op == 2'd0);
      r_sb_write <= w_pop && (w_head_op == 2'd1);
      r_sb_flush <= w_pop && (w_head_op == 2'd2);

      if (w_pop) begin
        r_key    <= w_head_key;
        r_val    <= (w_head_op == 2'd1) ? w_head_val : '0;
        r_rsp_op <= w_head_op;
        if (w_head_op == 2'd3) begin
          r_rsp_err <= 1'b1;
          r_rsp_hit <= 1'b0;
          r_rsp_id  <= '0;
        end
      end

      if (r_state == S_ISSUE)
        r_cnt <= '0;
      else if (r_state == S_WAIT && !i_sb_ack)
        r_cnt <= r_cnt + 1'b1;

      if (r_state == S_WAIT) begin
        if (i_sb_ack) begin
          r_rsp_hit <= i_sb_exists;
          r_rsp_id  <= i_sb_id;
          r_rsp_err <= 1'b0;
        end else if (w_timeout) begin
          r_rsp_hit <= 1'b0;
          r_rsp_id  <= '0;
          r_rsp_err <= 1'b1;
        end
      end

      if (i_sb_ack && r_state != S_WAIT) r_spurious <= 1'b1;
    end
  end

  assign o_cmd_ready = !w_full;
  assign o_rsp_valid = (r_state == S_RESP);
  assign o_rsp_op    = r_rsp_op;
  assign o_rsp_hit   = r_rsp_hit;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_err   = r_rsp_err;
  assign o_sb_key    = r_key;
  assign o_sb_val    = r_val;
  assign o_sb_read   = r_sb_read;
  assign o_sb_write  = r_sb_write;
  assign o_sb_flush  = r_sb_flush;
  assign o_busy      = (r_state != S_IDLE) || !w_empty;
  assign o_spurious  = r_spurious;

endmodule
`default_nettype wire

// File: tb/tb_sb_requester.sv
`default_nettype none
// ============================================================================
// Module      : tb_sb_requester
// Description : Directed self-checking bench for sb_requester with a small
//               scoreboard responder model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sb_requester;

  localparam int c_TIMEOUT = 16;

  logic       clk, rst;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_key, cmd_val;
  logic       rsp_valid, rsp_ready, rsp_hit, rsp_err;
  logic [1:0] rsp_op, rsp_id;
  logic [7:0] sb_key, sb_val;
  logic       sb_read, sb_write, sb_flush;
  logic       sb_ack, sb_exists;
  logic [1:0] sb_id;
  logic       busy, spurious;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc_cyc, rsp_cyc, ack_cyc;

  bit         auto_ack  = 0;
  int         ack_delay = 1;
  int         ack_cnt   = 0;
  logic       mdl_exists = 0;
  logic [1:0] mdl_id     = 0;

  logic [1:0] log_op  [$];
  logic [7:0] log_key [$];
  logic [7:0] log_val [$];
  int         log_cyc [$];

  sb_requester #(
    .PROC_COUNT(4), .KEY_W(8), .VAL_W(8), .CMD_DEPTH(4), .TIMEOUT(c_TIMEOUT)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_op(cmd_op), .i_cmd_key(cmd_key), .i_cmd_val(cmd_val),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_op(rsp_op), .o_rsp_hit(rsp_hit), .o_rsp_id(rsp_id), .o_rsp_err(rsp_err),
    .o_sb_key(sb_key), .o_sb_val(sb_val),
    .o_sb_read(sb_read), .o_sb_write(sb_write), .o_sb_flush(sb_flush),
    .i_sb_ack(sb_ack), .i_sb_exists(sb_exists), .i_sb_id(sb_id),
    .o_busy(busy), .o_spurious(spurious)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard responder: logs every strobe and acks ack_delay cycles later.
  initial begin : sb_model
    sb_ack = 0; sb_exists = 0; sb_id = 0;
    forever begin
      @(negedge clk);
      sb_ack = 0;
      if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0) begin
          sb_ack = 1; sb_exists = mdl_exists; sb_id = mdl_id; ack_cyc = cyc;
        end
      end
      if (sb_read || sb_write || sb_flush) begin
        chk("strobe_onehot", $countones({sb_read, sb_write, sb_flush}), 1);
        log_op.push_back(sb_write ? 2'd1 : (sb_flush ? 2'd2 : 2'd0));
        log_key.push_back(sb_key);
        log_val.push_back(sb_val);
        log_cyc.push_back(cyc);
        if (auto_ack) ack_cnt = ack_delay;
      end
    end
  end

  task automatic push(input logic [1:0] op, input logic [7:0] k, input logic [7:0] v);
    int t = 0;
    cmd_op = op; cmd_key = k; cmd_val = v; cmd_valid = 1;
    while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
    chk("push_ready", {31'd0, cmd_ready}, 1);
    acc_cyc = cyc;
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic wait_rsp(input string tag, input logic [1:0] op, input logic hit,
                          input logic [1:0] id, input logic err, input int exp_log);
    int t = 0;
    while (!rsp_valid && t < 200) begin @(negedge clk); t++; end
    rsp_cyc = cyc;
    repeat (2) @(negedge clk);
    chk({tag, "_valid"}, {31'd0, rsp_valid}, 1);
    chk({tag, "_op"},  {30'd0, rsp_op}, {30'd0, op});
    chk({tag, "_hit"}, {31'd0, rsp_hit}, {31'd0, hit});
    chk({tag, "_id"},  {30'd0, rsp_id}, {30'd0, id});
    chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, err});
    if (exp_log >= 0) chk({tag, "_nstrobe"}, log_op.size(), exp_log);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask

  initial begin : stim
    int base, t, s;
    logic seen;
    rst = 1; cmd_valid = 0; cmd_op = 0; cmd_key = 0; cmd_val = 0; rsp_ready = 0;
    repeat (2) @(negedge clk);
    rst = 0;

    // Reset state
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("rst_strobes", {29'd0, sb_read, sb_write, sb_flush}, 0);
    chk("rst_spurious", {31'd0, spurious}, 0);
    chk("rst_sb_key", {24'd0, sb_key}, 0);
    chk("rst_rsp", {27'd0, rsp_op, rsp_hit, rsp_id}, 0);

    // LOOKUP key=2, ack 3 cycles after the strobe
    auto_ack = 1; ack_delay = 3; mdl_exists = 1; mdl_id = 3;
    push(2'd0, 8'd2, 8'h55);
    base = acc_cyc;
    wait_rsp("lookup", 2'd0, 1'b1, 2'd3, 1'b0, 1);
    chk("lookup_strobe_cyc", log_cyc[0], base + 2);
    chk("lookup_key", {24'd0, log_key[0]}, 2);
    chk("lookup_val_zero", {24'd0, log_val[0]}, 0);
    chk("lookup_rsp_lat", rsp_cyc, ack_cyc + 1);

    // Three back-to-back INSERTs
    ack_delay = 1; mdl_exists = 1; mdl_id = 2;
    push(2'd1, 8'd4, 8'd1);
    push(2'd1, 8'd6, 8'd2);
    push(2'd1, 8'd8, 8'd3);
    for (int i = 0; i < 3; i++) wait_rsp("insert", 2'd1, 1'b1, 2'd2, 1'b0, 2 + i);
    for (int i = 0; i < 3; i++) begin
      chk("insert_op", {30'd0, log_op[1+i]}, 1);
      chk("insert_key", {24'd0, log_key[1+i]}, 4 + 2 * i);
      chk("insert_val", {24'd0, log_val[1+i]}, 1 + i);
    end

    // Fill the FIFO behind a stalled response
    ack_delay = 2; mdl_exists = 0; mdl_id = 1;
    base = log_op.size();
    for (int i = 0; i < 5; i++) push(2'd0, 8'(10 + i), 8'd0);
    chk("full_ready", {31'd0, cmd_ready}, 0);
    chk("full_busy", {31'd0, busy}, 1);
    cmd_op = 0; cmd_key = 8'd99; cmd_valid = 1;
    for (int i = 0; i < 3; i++) begin
      chk("full_ready_hold", {31'd0, cmd_ready}, 0);
      chk("stall_rsp_valid", {31'd0, rsp_valid}, 1);
      chk("stall_rsp_id", {30'd0, rsp_id}, 1);
      @(negedge clk);
    end
    cmd_valid = 0;
    for (int i = 0; i < 5; i++) wait_rsp("fill", 2'd0, 1'b0, 2'd1, 1'b0, base + 1 + i);
    repeat (3) @(negedge clk);
    chk("fill_nstrobe", log_op.size(), base + 5);
    for (int i = 0; i < 5; i++) chk("fill_key_order", {24'd0, log_key[base+i]}, 10 + i);
    chk("drain_busy", {31'd0, busy}, 0);
    chk("drain_ready", {31'd0, cmd_ready}, 1);

    // Ack in the final WAIT cycle beats the timeout
    ack_delay = c_TIMEOUT; mdl_exists = 1; mdl_id = 1;
    push(2'd0, 8'd3, 8'd0);
    wait_rsp("ackwins", 2'd0, 1'b1, 2'd1, 1'b0, base + 6);
    chk("ackwins_lat", rsp_cyc, log_cyc[base+5] + c_TIMEOUT + 1);
    chk("ackwins_spurious", {31'd0, spurious}, 0);

    // RELEASE times out; its late ack lands in RESP
    ack_delay = c_TIMEOUT + 1; mdl_exists = 1; mdl_id = 3;
    push(2'd2, 8'd8, 8'h77);
    wait_rsp("timeout", 2'd2, 1'b0, 2'd0, 1'b1, base + 7);
    chk("timeout_lat", rsp_cyc, log_cyc[base+6] + 1 + c_TIMEOUT);
    chk("release_key", {24'd0, log_key[base+6]}, 8);
    chk("release_val", {24'd0, log_val[base+6]}, 0);
    chk("late_ack_spurious", {31'd0, spurious}, 1);

    // Reserved op: no strobe, error response
    push(2'd3, 8'd5, 8'h12);
    wait_rsp("reserved", 2'd3, 1'b0, 2'd0, 1'b1, base + 7);

    // Reset during WAIT, then the ack arrives
    ack_delay = 3;
    push(2'd0, 8'd7, 8'd0);
    t = 0;
    while (!sb_read && t < 50) begin @(negedge clk); t++; end
    chk("rstwait_strobe", {31'd0, sb_read}, 1);
    s = log_op.size();
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rstwait_spurious_clr", {31'd0, spurious}, 0);
    chk("rstwait_ready", {31'd0, cmd_ready}, 1);
    chk("rstwait_busy", {31'd0, busy}, 0);
    repeat (2) @(negedge clk);
    chk("rstwait_spurious", {31'd0, spurious}, 1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      seen = seen | rsp_valid;
      @(negedge clk);
    end
    chk("rstwait_no_rsp", {31'd0, seen}, 0);
    chk("rstwait_no_strobe", log_op.size(), s);
    chk("rstwait_busy_end", {31'd0, busy}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
